// File: rtl/parity_gen.sv
// ============================================================================
// Module      : parity_gen
// Description : Appends an even/odd parity bit to each payload word and
//               delivers it through a two-entry (output + skid) buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  grant_o,
    output logic [DATA_WIDTH:0]   data_o,
    output logic                  valid_o,
    input  logic                  grant_i,
    output logic [15:0]           count_o
);

    localparam logic c_parity_odd = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH:0]   r_out_data;
    logic [DATA_WIDTH:0]   r_skid_data;
    logic [15:0]           r_count;

    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_load_out;
    logic                  w_load_skid;
    logic                  w_skid_to_out;
    logic [DATA_WIDTH:0]   w_word;

    // Handshake outputs depend only on the state register.
    assign grant_o    = (r_state != TWO);
    assign valid_o    = (r_state != EMPTY);
    assign data_o     = r_out_data;
    assign count_o    = r_count;

    assign w_in_xfer  = valid_i & grant_o;
    assign w_out_xfer = valid_o & grant_i;
    assign w_word     = {(^data_i) ^ c_parity_odd, data_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_load_out  = 1'b1;
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_out  = 1'b1;
                end else if (w_in_xfer) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = TWO;
                end else if (w_out_xfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_out_xfer) begin
                    w_skid_to_out = 1'b1;
                    w_state_nxt   = ONE;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_out) begin
                r_out_data <= w_word;
            end else if (w_skid_to_out) begin
                r_out_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= w_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (w_out_xfer) begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: doc/parity_gen.md
PARITY_GEN -- requirements
Module: parity_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the payload width in bits.
REQ-002 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_i  input  DATA_WIDTH  upstream payload.
REQ-006 SHALL have port valid_i  input  1  upstream payload valid.
REQ-007 SHALL have port grant_o  output  1  block can accept a word this cycle.
REQ-008 SHALL have port data_o  output  DATA_WIDTH+1  {parity bit, payload} toward the FIFO push side.
REQ-009 SHALL have port valid_o  output  1  data_o valid.
REQ-010 SHALL have port grant_i  input  1  downstream accepts data_o this cycle.
REQ-011 SHALL have port count_o  output  16  number of words delivered downstream.

Function
REQ-012 SHALL treat an input transfer as valid_i=1 and grant_o=1 in the same cycle, and an output transfer as valid_o=1 and grant_i=1 in the same cycle.
REQ-013 SHALL compute parity as the XOR reduction of data_i, XORed with PARITY_ODD, at input-transfer time.
REQ-014 SHALL drive data_o[DATA_WIDTH] with the parity bit and data_o[DATA_WIDTH-1:0] with the unmodified payload.
REQ-015 SHALL implement a two-entry buffer with an output register and a skid register, controlled by FSM states EMPTY, ONE and TWO.
REQ-016 SHALL behave in EMPTY as follows: valid_o=0, grant_o=1; an input transfer loads the output register and moves to ONE.
REQ-017 SHALL behave in ONE as follows: valid_o=1, grant_o=1.
- input transfer only: loads skid, moves to TWO.
- output transfer only: moves to EMPTY.
- both in the same cycle: loads the output register with the new word, stays in ONE.
REQ-018 SHALL behave in TWO as follows: valid_o=1, grant_o=0; an output transfer copies skid to the output register and moves to ONE.
REQ-019 SHALL drive grant_o only from registered state, with no combinational path from grant_i or valid_i.
REQ-020 SHALL present an accepted word on data_o/valid_o the cycle after its input transfer when the buffer was EMPTY (latency 1).
REQ-021 SHALL hold data_o and valid_o stable while valid_o=1 and grant_i=0.
REQ-022 SHALL deliver words in acceptance order, with no loss or duplication.
REQ-023 SHALL ignore data_i when valid_i=0 or grant_o=0.
REQ-024 SHALL increment count_o by 1 on every output transfer, wrapping from 16'hFFFF to 16'h0000.
REQ-025 SHALL NOT change count_o in cycles without an output transfer.

Reset
REQ-026 SHALL, while rst=1 and independent of clk, force state EMPTY, valid_o=0, grant_o=1, count_o=0, data_o=0.
REQ-027 SHALL discard buffered words when reset is asserted mid-operation, and output none of them after release.
REQ-028 SHALL accept an input transfer on the first rising clk edge after rst deasserts.

Verification
REQ-029 SHALL cover a single word with DATA_WIDTH=8, PARITY_ODD=0: data_i=8'hA5 (4 ones), grant_i=1 -> next cycle data_o=9'h0A5, valid_o=1, then count_o=1.
REQ-030 SHALL cover odd parity: PARITY_ODD=1, data_i=8'h01 -> data_o=9'h001; data_i=8'h00 -> data_o=9'h100.
REQ-031 SHALL cover backpressure: grant_i=0 with 3 words offered (8'h11, 8'h22, 8'h33).
- two are accepted; grant_o=0 after the second; data_o holds 8'h11 stable.
- when grant_i=1 the words emerge as 11, 22, 33 in order, with no gaps once grant_i stays high.
REQ-032 SHALL cover streaming: valid_i=1 and grant_i=1 for 100 cycles with an incrementing payload -> 100 words out in order, grant_o constantly 1, count_o=100.
REQ-033 SHALL cover counter wrap: 65537 output transfers -> count_o reads 16'h0001.
REQ-034 SHALL cover reset in state TWO: rst asserted asynchronously -> valid_o=0, grant_o=1 and count_o=0 immediately; no stale word appears after release.
